// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
// Feeds one frame of pixels from a ready/valid source into a convolution
// datapath, then tags the returned results with their raster position.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   start, cfg_rows/cols/kernel frame request and its geometry
//   s_pixel/s_valid/s_ready     source pixel stream
//   cnn_*  (out)                pixel stream + latched config to the datapath
//   cnn_conv_res/cnn_valid_out  datapath result stream
//   m_pixel/m_valid/m_row/m_col tagged result stream
//   busy, done, err             status
//
// Build option: CNN_SEQ_TIMEOUT_EN enables the DRAIN watchdog that sends the
// block to ERR after TIMEOUT_CYCLES consecutive cycles without a result.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting source pixels (results may already be returning)
// DRAIN | all pixels sent, collecting remaining results
// DONE  | frame complete, done pulses for this one cycle
// ERR   | drain watchdog expired, held until start or rst

module cnn_frame_sequencer #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int BUFFER_LENGTH  = 2000,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CNT_W         = $clog2(BUFFER_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_rows,
    input  logic [CNT_W-1:0]       cfg_cols,
    input  logic [4:0]             cfg_kernel,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [PIXEL_WIDTH-1:0] cnn_in_point,
    output logic                   cnn_valid_in,
    output logic [CNT_W-1:0]       cnn_frame_column_size,
    output logic [CNT_W-1:0]       cnn_frame_row_size,
    output logic [4:0]             cnn_kernel_type,
    input  logic [PIXEL_WIDTH-1:0] cnn_conv_res,
    input  logic                   cnn_valid_out,
    output logic [PIXEL_WIDTH-1:0] m_pixel,
    output logic                   m_valid,
    output logic [CNT_W-1:0]       m_row,
    output logic [CNT_W-1:0]       m_col,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam int TOT_W  = 2 * CNT_W;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    logic [2:0]       r_state;
    logic [TOT_W-1:0] r_in_cnt;
    logic [TOT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [IDLE_W-1:0] r_idle_tmr;

    logic [TOT_W-1:0] w_total;
    logic             w_active;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_in_last;
    logic             w_res_acc;
    logic             w_out_last;
    logic             w_timeout;

    assign w_total    = TOT_W'(cnn_frame_row_size) * TOT_W'(cnn_frame_column_size);
    assign w_active   = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    assign s_ready    = (r_state == S_LOAD) && (r_in_cnt < w_total);
    assign w_xfer     = s_valid && s_ready;
    assign w_in_last  = w_xfer && (r_in_cnt == w_total - TOT_W'(1));

    assign w_res_acc  = cnn_valid_out && w_active && (r_out_cnt < w_total);
    assign w_out_last = w_res_acc && (r_out_cnt == w_total - TOT_W'(1));

    // Down-counting watchdog: reloaded on every result, expires on the cycle
    // it would count past one, i.e. TIMEOUT_CYCLES idle DRAIN cycles.
    assign w_timeout  = TIMEOUT_EN && (r_state == S_DRAIN) && !cnn_valid_out
                        && (r_idle_tmr == IDLE_W'(1));

    assign busy = w_active;
    assign done = (r_state == S_DONE);
`ifdef CNN_SEQ_TIMEOUT_EN
    assign err  = (r_state == S_ERR);
`else
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state               <= S_IDLE;
            r_in_cnt              <= '0;
            r_out_cnt             <= '0;
            r_row                 <= '0;
            r_col                 <= '0;
            r_idle_tmr            <= IDLE_W'(TIMEOUT_CYCLES);
            cnn_in_point          <= '0;
            cnn_valid_in          <= 1'b0;
            cnn_frame_column_size <= '0;
            cnn_frame_row_size    <= '0;
            cnn_kernel_type       <= '0;
            m_pixel               <= '0;
            m_valid               <= 1'b0;
            m_row                 <= '0;
            m_col                 <= '0;
        end else begin
            cnn_valid_in <= w_xfer;
            if (w_xfer) begin
                cnn_in_point <= s_pixel;
                r_in_cnt     <= r_in_cnt + TOT_W'(1);
            end

            m_valid <= w_res_acc;
            if (w_res_acc) begin
                m_pixel   <= cnn_conv_res;
                m_row     <= r_row;
                m_col     <= r_col;
                r_out_cnt <= r_out_cnt + TOT_W'(1);
                if (r_col == cnn_frame_column_size - CNT_W'(1)) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
            end

            if ((r_state != S_DRAIN) || cnn_valid_out) begin
                r_idle_tmr <= IDLE_W'(TIMEOUT_CYCLES);
            end else if (r_idle_tmr != IDLE_W'(1)) begin
                r_idle_tmr <= r_idle_tmr - IDLE_W'(1);
            end

            case (r_state)
                S_LOAD: begin
                    if (w_out_last)     r_state <= S_DONE;
                    else if (w_in_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_out_last)     r_state <= S_DONE;
                    else if (w_timeout) r_state <= S_ERR;
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase

            // Start is only honoured in IDLE/DONE/ERR, where no transfer or
            // result can be in flight, so it safely overrides the above.
            if (w_start_ok) begin
                cnn_frame_row_size    <= cfg_rows;
                cnn_frame_column_size <= cfg_cols;
                cnn_kernel_type       <= cfg_kernel;
                r_in_cnt              <= '0;
                r_out_cnt             <= '0;
                r_row                 <= '0;
                r_col                 <= '0;
                r_idle_tmr            <= IDLE_W'(TIMEOUT_CYCLES);
                if ((cfg_rows == '0) || (cfg_cols == '0)) r_state <= S_DONE;
                else                                      r_state <= S_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
module tb_cnn_frame_sequencer;

    localparam int PW = 8;
    localparam int BL = 2000;
    localparam int CW = $clog2(BL);
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_rows = '0;
    logic [CW-1:0] cfg_cols = '0;
    logic [4:0]    cfg_kernel = '0;
    logic [PW-1:0] s_pixel = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] cnn_in_point;
    logic          cnn_valid_in;
    logic [CW-1:0] cnn_frame_column_size;
    logic [CW-1:0] cnn_frame_row_size;
    logic [4:0]    cnn_kernel_type;
    logic [PW-1:0] cnn_conv_res = '0;
    logic          cnn_valid_out = 1'b0;
    logic [PW-1:0] m_pixel;
    logic          m_valid;
    logic [CW-1:0] m_row;
    logic [CW-1:0] m_col;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    cnn_frame_sequencer #(
        .PIXEL_WIDTH   (PW),
        .BUFFER_LENGTH (BL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .cfg_rows             (cfg_rows),
        .cfg_cols             (cfg_cols),
        .cfg_kernel           (cfg_kernel),
        .s_pixel              (s_pixel),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .cnn_in_point         (cnn_in_point),
        .cnn_valid_in         (cnn_valid_in),
        .cnn_frame_column_size(cnn_frame_column_size),
        .cnn_frame_row_size   (cnn_frame_row_size),
        .cnn_kernel_type      (cnn_kernel_type),
        .cnn_conv_res         (cnn_conv_res),
        .cnn_valid_out        (cnn_valid_out),
        .m_pixel              (m_pixel),
        .m_valid              (m_valid),
        .m_row                (m_row),
        .m_col                (m_col),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Negedge monitor: counts events and checks cnn_valid_in/cnn_in_point
    // against the transfer seen one cycle earlier.
    int            vin_cnt, vin_bad, sready_cnt, done_cnt, m_cnt;
    logic [PW-1:0] vin_val [0:31];
    logic [PW-1:0] mp [0:31];
    logic [CW-1:0] mr [0:31];
    logic [CW-1:0] mc [0:31];
    logic          exp_vin = 1'b0;
    logic [PW-1:0] exp_pix = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_vin = 1'b0;
        end else begin
            if ((cnn_valid_in !== exp_vin) || (exp_vin && (cnn_in_point !== exp_pix))) vin_bad++;
            if (cnn_valid_in === 1'b1) begin
                if (vin_cnt < 32) vin_val[vin_cnt] = cnn_in_point;
                vin_cnt++;
            end
            if (s_ready === 1'b1) sready_cnt++;
            if (done === 1'b1) done_cnt++;
            if (m_valid === 1'b1) begin
                if (m_cnt < 32) begin
                    mp[m_cnt] = m_pixel;
                    mr[m_cnt] = m_row;
                    mc[m_cnt] = m_col;
                end
                m_cnt++;
            end
            exp_vin = s_valid && s_ready;
            exp_pix = s_pixel;
        end
    end

    task automatic clear_mon();
        vin_cnt = 0; vin_bad = 0; sready_cnt = 0; done_cnt = 0; m_cnt = 0;
    endtask

    task automatic do_start(input int rows, input int cols, input int kern);
        cfg_rows   = rows[CW-1:0];
        cfg_cols   = cols[CW-1:0];
        cfg_kernel = kern[4:0];
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_pix(input int first, input int last, input bit toggle);
        int   p;
        int   cyc;
        logic xfer;
        p   = first;
        cyc = 0;
        while (p <= last && cyc < 400) begin
            s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            s_pixel = p[PW-1:0];
            @(negedge clk);
            xfer = s_valid && s_ready;
            @(posedge clk); #1;
            if (xfer) p++;
            cyc++;
        end
        s_valid = 1'b0;
        check_val("pixels_sent", p, last + 1);
    endtask

    task automatic send_res(input int n, input int base);
        int v;
        for (int i = 0; i < n; i++) begin
            v             = base + i;
            cnn_valid_out = 1'b1;
            cnn_conv_res  = v[PW-1:0];
            @(posedge clk); #1;
        end
        cnn_valid_out = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_m_valid", m_valid, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // 3x3, continuous source
        clear_mon();
        do_start(3, 3, 5);
        check_val("t1_rows", cnn_frame_row_size, 3);
        check_val("t1_kernel", cnn_kernel_type, 5);
        check_val("t1_busy", busy, 1);
        send_pix(1, 9, 0);
        send_res(9, 50);
        wait_cyc(2);
        check_val("t1_sready_cyc", sready_cnt, 9);
        check_val("t1_vin_cnt", vin_cnt, 9);
        check_val("t1_vin_first", vin_val[0], 1);
        check_val("t1_vin_last", vin_val[8], 9);
        check_val("t1_vin_model", vin_bad, 0);
        check_val("t1_done_cnt", done_cnt, 1);
        check_val("t1_m_cnt", m_cnt, 9);
        check_val("t1_m_pix8", mp[8], 58);
        check_val("t1_m_row8", mr[8], 2);
        check_val("t1_m_col8", mc[8], 2);
        check_val("t1_idle_busy", busy, 0);

        // 4x5, toggling source, one extra result
        clear_mon();
        do_start(4, 5, 3);
        send_pix(1, 20, 1);
        send_res(21, 100);
        wait_cyc(2);
        check_val("t2_vin_cnt", vin_cnt, 20);
        check_val("t2_vin_model", vin_bad, 0);
        check_val("t2_vin_last", vin_val[19], 20);
        check_val("t2_sready_cyc", sready_cnt, 39);
        check_val("t2_m_cnt", m_cnt, 20);
        check_val("t2_m_row7", mr[7], 1);
        check_val("t2_m_col7", mc[7], 2);
        check_val("t2_m_pix7", mp[7], 107);
        check_val("t2_m_row19", mr[19], 3);
        check_val("t2_m_col19", mc[19], 4);
        check_val("t2_done_cnt", done_cnt, 1);

        // start ignored during LOAD
        clear_mon();
        do_start(3, 3, 1);
        send_pix(1, 3, 0);
        do_start(6, 3, 7);
        check_val("t3_rows_held", cnn_frame_row_size, 3);
        check_val("t3_kernel_held", cnn_kernel_type, 1);
        check_val("t3_busy", busy, 1);
        send_pix(4, 9, 0);
        send_res(9, 0);
        wait_cyc(2);
        check_val("t3_vin_cnt", vin_cnt, 9);
        check_val("t3_vin_model", vin_bad, 0);
        check_val("t3_done_cnt", done_cnt, 1);

        // async reset mid-frame, then restart
        clear_mon();
        do_start(3, 3, 2);
        send_pix(1, 4, 0);
        #2 rst = 1'b1;
        #1;
        check_val("t4_vin_async", cnn_valid_in, 0);
        check_val("t4_pix_async", cnn_in_point, 0);
        check_val("t4_rows_async", cnn_frame_row_size, 0);
        check_val("t4_kernel_async", cnn_kernel_type, 0);
        check_val("t4_busy_async", busy, 0);
        check_val("t4_sready_async", s_ready, 0);
        cfg_rows = CW'(3); cfg_cols = CW'(3); cfg_kernel = 5'd2;
        start = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        clear_mon();
        @(posedge clk); #1 start = 1'b0;
        check_val("t4_start_on_release", busy, 1);
        send_pix(1, 9, 0);
        send_res(9, 10);
        wait_cyc(2);
        check_val("t4_vin_cnt", vin_cnt, 9);
        check_val("t4_vin_first", vin_val[0], 1);
        check_val("t4_vin_model", vin_bad, 0);
        check_val("t4_done_cnt", done_cnt, 1);

        // zero-row frame
        clear_mon();
        do_start(0, 3, 0);
        check_val("t5_busy", busy, 0);
        wait_cyc(2);
        check_val("t5_done_cnt", done_cnt, 1);
        check_val("t5_vin_cnt", vin_cnt, 0);
        check_val("t5_sready_cyc", sready_cnt, 0);

        // results stop after 5
        clear_mon();
        do_start(3, 3, 4);
        send_pix(1, 9, 0);
        send_res(5, 20);
`ifdef CNN_SEQ_TIMEOUT_EN
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("t6_err_delay", k, 16);
        check_val("t6_busy_err", busy, 0);
        check_val("t6_done_cnt", done_cnt, 0);
        do_start(3, 3, 4);
        check_val("t6_err_cleared", err, 0);
        check_val("t6_busy_restart", busy, 1);
`else
        k = 0;
        wait_cyc(40);
        check_val("t6_err_tied", err, 0);
        check_val("t6_busy_drain", busy, 1);
        check_val("t6_done_cnt", done_cnt + k, 0);
`endif
        rst = 1'b1;
        #3;
        check_val("t6_busy_rst", busy, 0);
        rst = 1'b0;
        wait_cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: pixel and result width.
REQ-002 Parameter BUFFER_LENGTH, default 2000: max row/column size; CNT_W = clog2(BUFFER_LENGTH).
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: drain watchdog limit (used only with REQ-030).
REQ-004 One clock; reset is asynchronous and active-high. Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-005 start  in  1  frame start request; cfg_rows  in  CNT_W  frame rows; cfg_cols  in  CNT_W  frame columns; cfg_kernel  in  5  kernel select.
REQ-006 s_pixel  in  PIXEL_WIDTH  source pixel; s_valid  in  1  source valid; s_ready  out  1  sequencer accepts pixel.
REQ-007 cnn_in_point  out  PIXEL_WIDTH; cnn_valid_in  out  1; cnn_frame_column_size  out  CNT_W; cnn_frame_row_size  out  CNT_W; cnn_kernel_type  out  5: drive the convolution datapath.
REQ-008 cnn_conv_res  in  PIXEL_WIDTH; cnn_valid_out  in  1: datapath result stream.
REQ-009 m_pixel  out  PIXEL_WIDTH; m_valid  out  1; m_row  out  CNT_W; m_col  out  CNT_W: tagged result stream.
REQ-010 busy  out  1; done  out  1; err  out  1.

Function
REQ-011 States IDLE, LOAD, DRAIN, DONE, ERR.
REQ-012 start is accepted only in IDLE, DONE or ERR; it is ignored in LOAD/DRAIN.
REQ-013 On accepted start: latch cfg_rows/cfg_cols/cfg_kernel into cnn_frame_row_size/cnn_frame_column_size/cnn_kernel_type, clear all counters and err, and go to LOAD; these outputs hold until the next accepted start.
REQ-014 total = rows*cols, computed at 2*CNT_W bits without truncation.
REQ-015 An accepted start with rows==0 or cols==0 goes directly to DONE and issues no pixels.
REQ-016 s_ready = 1 only in LOAD while in_cnt < total; a pixel is transferred when s_valid && s_ready.
REQ-017 cnn_valid_in and cnn_in_point are registered copies of the transfer, with 1-cycle latency and at most one pixel per cycle; cnn_valid_in = 0 on cycles without a transfer.
REQ-018 LOAD goes to DRAIN on the cycle the last pixel (in_cnt == total-1) transfers.
REQ-019 In LOAD/DRAIN, each cnn_valid_out while out_cnt < total increments out_cnt and produces a 1-cycle-latency registered m_valid/m_pixel = cnn_conv_res.
REQ-020 m_row/m_col give the raster position of the output: col wraps at cols-1 to 0 and row then increments.
REQ-021 cnn_valid_out outside LOAD/DRAIN, or once out_cnt == total, is dropped (m_valid stays 0).
REQ-022 The sequencer enters DONE when out_cnt reaches total. If this happens on the same cycle as the last pixel transfer, it goes LOAD to DONE directly.
REQ-023 done is a 1-cycle pulse on entry to DONE; DONE then returns to IDLE unless start is asserted in that cycle.
REQ-024 busy = 1 in LOAD and DRAIN, 0 otherwise.

Reset
REQ-025 rst asserted forces state IDLE and zeroes, without waiting for clk: all counters, s_ready, cnn_valid_in, cnn_in_point, the cnn_* config outputs, m_valid, m_pixel, m_row, m_col, busy, done and err.
REQ-026 A reset in LOAD/DRAIN aborts the frame; the next start restarts from pixel 0.
REQ-027 Release of rst takes effect at the next clk edge; start sampled on that edge is honoured.

Configuration
REQ-028 The macro is CNN_SEQ_TIMEOUT_EN.
REQ-029 Without CNN_SEQ_TIMEOUT_EN: err is tied 0, ERR is unreachable, and DRAIN waits indefinitely.
REQ-030 With CNN_SEQ_TIMEOUT_EN: an idle counter counts consecutive DRAIN cycles without cnn_valid_out and resets on each cnn_valid_out.
REQ-031 With CNN_SEQ_TIMEOUT_EN, when the idle counter reaches TIMEOUT_CYCLES the block enters ERR: err = 1 and is held, no done pulse, busy = 0; only start or rst clears it.

Verification
REQ-032 3x3 frame, s_valid held high, pixels 1..9, datapath returns 9 results -> s_ready high for exactly 9 cycles, cnn_valid_in pulses 9 times one cycle later carrying 1..9, done pulses once.
REQ-033 4x5 frame, s_valid toggling every cycle -> exactly 20 cnn_valid_in pulses in order, and no transfer when s_valid = 0.
REQ-034 4x5 frame, 8th result (index 7) -> m_row = 1, m_col = 2; a 21st cnn_valid_out is dropped.
REQ-035 start with rows = 6 asserted during LOAD of a 3x3 frame -> ignored; cnn_frame_row_size stays 3.
REQ-036 rst asserted after 4 of 9 pixels -> all outputs 0 immediately; a new 3x3 start re-sends 9 pixels and done follows.
REQ-037 CNN_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, 3x3 frame with results stopping after 5 -> err rises 16 cycles after the last cnn_valid_out, done never pulses, and the next start clears err.
